pwm_rise_fall_scheduler: RTL

Sequences per-transducer duty/phase into rise/fall edge values for the PWM stage. On each START it walks all DEPTH channels of a duty/phase memory (1-cycle read latency), computes wrapped rise/fall edges against the current carrier cycle, and writes them to the per-channel edge registers that feed the per-channel PWM buffers. It flags any update that is still in flight when the carrier reaches its last count, because the buffers would then latch a mixed old/new set.

---
 rtl/pwm_sched_pkg.sv | 23 ++
 rtl/pwm_edge_calc.sv | 57 +++++
 rtl/pwm_rise_fall_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM rise/fall edge scheduler.
package pwm_sched_pkg;

    // Default carrier/duty/phase/edge width; the edge struct is sized by it.
    localparam int PWM_W = 13;

    // Number of cycles spent flushing the read stage and the compute stage.
    localparam int DRAIN_LEN = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PWM_W-1:0] rise;
        logic [PWM_W-1:0] fall;
        logic             full_width;
    } pwm_edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Registered edge arithmetic: turns one duty/phase pair into wrapped
// rise/fall edges against the carrier period CYCLE_M1+1. Latency 1 cycle.
module pwm_edge_calc
    import pwm_sched_pkg::*;
#(
    parameter int WIDTH = PWM_W
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] CYCLE_M1,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] phase,
    output pwm_edge_t        edge_out
);

    logic [WIDTH:0] period;
    logic [WIDTH:0] duty_x;
    logic [WIDTH:0] phase_x;
    logic [WIDTH:0] h_lo;
    logic [WIDTH:0] h_hi;
    logic [WIDTH:0] rise_x;
    logic [WIDTH:0] fall_x;
    logic           full_x;

    // Wrapped edge arithmetic, one bit wider than the carrier so wraps are visible.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        period  = {1'b0, CYCLE_M1} + (WIDTH+1)'(1);
        duty_x  = {1'b0, duty};
        phase_x = {1'b0, phase};
        h_lo    = duty_x >> 1;
        h_hi    = (duty_x + (WIDTH+1)'(1)) >> 1;
        rise_x  = phase_x - h_lo;
        fall_x  = phase_x + h_hi;
        full_x  = (duty_x >= period);
        // A set MSB means phase - h_lo went negative: wrap forward by one period.
        if (rise_x[WIDTH]) begin
            rise_x = rise_x + period;
        end
        if (fall_x >= period) begin
            fall_x = fall_x - period;
        end
    end

    // Register the result; full width pins both edges to the phase.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            edge_out <= '0;
        end else begin
            edge_out.full_width <= full_x;
            edge_out.rise       <= full_x ? phase : rise_x[WIDTH-1:0];
            edge_out.fall       <= full_x ? phase : fall_x[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pwm_rise_fall_scheduler.sv
// Sweeps all channels of a duty/phase memory on START and writes the
// computed rise/fall edges to the per-channel edge registers.
// Optional feature: define PWM_SCHED_LATE_DETECT_EN to enable the LATE flag
// (an update still in flight when the carrier hits its last count).
module pwm_rise_fall_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int WIDTH  = PWM_W,
    parameter int DEPTH  = 249,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [WIDTH-1:0]  CYCLE_M1,
    input  logic [WIDTH-1:0]  TIME_CNT,
    input  logic              START,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [WIDTH-1:0]  DUTY_IN,
    input  logic [WIDTH-1:0]  PHASE_IN,
    output logic              WE,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [WIDTH-1:0]  RISE_OUT,
    output logic [WIDTH-1:0]  FALL_OUT,
    output logic              FULL_WIDTH_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN,
    output logic              LATE,
    input  logic              FLAG_CLR
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        drain_cnt_q;
    logic              last_addr;
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              we_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              overrun_q;
    pwm_edge_t         edge_q;

    assign last_addr = (rd_addr_q == ADDR_W'(DEPTH - 1));

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_d = state_q;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY = 1'b1;
                if (last_addr) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                BUSY = 1'b1;
                if (drain_cnt_q == 2'(DRAIN_LEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read address walk and drain cycle counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && START) begin
                rd_addr_q <= '0;
            end else if (state_q == ST_RUN && !last_addr) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 2'd1 : 2'd0;
        end
    end

    // Valid/address pipeline matching memory read plus edge compute latency.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            s1_valid_q <= (state_q == ST_RUN);
            s1_addr_q  <= rd_addr_q;
            we_q       <= s1_valid_q;
            wr_addr_q  <= s1_addr_q;
        end
    end

    // Sticky OVERRUN: a START outside IDLE; a new event beats FLAG_CLR.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overrun_q <= 1'b0;
        end else if (START && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
        end else if (FLAG_CLR) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef PWM_SCHED_LATE_DETECT_EN
    logic late_q;

    // Sticky LATE: carrier at its last count while a sweep is in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            late_q <= 1'b0;
        end else if (BUSY && TIME_CNT == CYCLE_M1) begin
            late_q <= 1'b1;
        end else if (FLAG_CLR) begin
            late_q <= 1'b0;
        end
    end

    assign LATE = late_q;
`else
    // Carrier count is only needed for LATE detection.
    logic unused_time_cnt;
    assign unused_time_cnt = ^TIME_CNT;
    assign LATE            = 1'b0;
`endif

    pwm_edge_calc #(
        .WIDTH (WIDTH)
    ) u_edge_calc (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .CYCLE_M1 (CYCLE_M1),
        .duty     (DUTY_IN),
        .phase    (PHASE_IN),
        .edge_out (edge_q)
    );

    assign RD_ADDR        = rd_addr_q;
    assign WE             = we_q;
    assign WR_ADDR        = wr_addr_q;
    assign RISE_OUT       = edge_q.rise;
    assign FALL_OUT       = edge_q.fall;
    assign FULL_WIDTH_OUT = edge_q.full_width;
    assign OVERRUN        = overrun_q;

endmodule
